// File: rtl/edac_scrubber_pkg.sv
// Shared definitions for the EDAC RAM scrubber: state encoding, default
// geometry and the CPU-visible register map for the scrub controls.
package edac_scrubber_pkg;

  // Default geometry of the triple-redundant RAM behind ECS0/ECS1.
  localparam int DEF_ADDR_W    = 19;
  localparam int DEF_NUM_BANKS = 2;
  localparam int DEF_ACC_CYC   = 3;
  localparam int DEF_CNT_W     = 8;

  // Width of the per-strobe access counter; covers ACC_CYC up to 15.
  localparam int ACC_W = 4;

  // I/O register offsets seen by the CPU decode.
  localparam logic [7:0] REG_SCRUB_CTRL     = 8'h20;  // bit0 = scrub enable
  localparam logic [7:0] REG_SCRUB_INTERVAL = 8'h22;  // 16-bit idle gap
  localparam logic [7:0] REG_CORR_CNT       = 8'h24;  // correction count, read
  localparam logic [7:0] REG_CORR_CNT_RC    = 8'h25;  // correction count, read-and-clear

  // Scrubber sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_REQ   = 3'd2,
    ST_READ  = 3'd3,
    ST_VOTE  = 3'd4,
    ST_WRITE = 3'd5,
    ST_NEXT  = 3'd6
  } scrub_state_t;

  // Register selected by a CPU I/O offset.
  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_CTRL     = 3'd1,
    SEL_INTERVAL = 3'd2,
    SEL_CNT      = 3'd3,
    SEL_CNT_RC   = 3'd4
  } scrub_reg_sel_t;

  // Decode an I/O offset into the scrubber register it addresses.
  function automatic scrub_reg_sel_t scrub_reg_sel(input logic [7:0] offset);
    scrub_reg_sel_t sel;
    sel = SEL_NONE;
    if (offset == REG_SCRUB_CTRL)          sel = SEL_CTRL;
    else if (offset == REG_SCRUB_INTERVAL) sel = SEL_INTERVAL;
    else if (offset == REG_CORR_CNT)       sel = SEL_CNT;
    else if (offset == REG_CORR_CNT_RC)    sel = SEL_CNT_RC;
    return sel;
  endfunction

  // States in which the scrubber wants the RAM port.
  function automatic logic state_owns_port(input scrub_state_t s);
    return (s == ST_READ) || (s == ST_VOTE) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/edac_scrubber_if.sv
// RAM-port bundle between the scrubber and the RAM mux.
//
// Port ownership: the scrubber uses the RAM port only in a cycle where
// grant is high. grant already folds in cpu_req and scrub_en, so the mux
// selects on grant alone; mem_rd/mem_wr are never high without grant, and
// the CPU is never stalled because cpu_req drops grant in the same cycle.
interface edac_scrubber_if
  import edac_scrubber_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              grant;
  logic              mem_bank;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_rdata0;
  logic [7:0]        mem_rdata1;
  logic [7:0]        mem_rdata2;
  logic [7:0]        mem_wdata;

  // Scrubber side.
  modport master (
    output grant,
    output mem_bank,
    output mem_adr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata0,
    input  mem_rdata1,
    input  mem_rdata2
  );

  // RAM mux side.
  modport slave (
    input  grant,
    input  mem_bank,
    input  mem_adr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata0,
    output mem_rdata1,
    output mem_rdata2
  );

endinterface

// File: rtl/edac_scrubber_tmr_vote8.sv
// Bitwise 2-of-3 majority over three byte copies, plus a flag that is set
// when any copy differs from the voted value. Shared with the CPU-read
// EDAC path, so it stays purely combinational.
module tmr_vote8 (
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  output logic [7:0] vote,
  output logic       mismatch
);

  // Majority per bit, then compare every copy against it.
  always_comb begin
    vote     = (d0 & d1) | (d1 & d2) | (d0 & d2);
    mismatch = (d0 != vote) || (d1 != vote) || (d2 != vote);
  end

endmodule

// File: rtl/edac_scrubber.sv
// Background scrubber for the triple-redundant EDAC RAM. Walks every word
// of every bank in idle bus time, votes the three copies and writes the
// voted byte back when they disagree. The CPU always wins the RAM port:
// any cpu_req while the scrubber owns the port aborts the word, and the
// word is re-read from scratch so a CPU write is never clobbered.
module edac_scrubber
  import edac_scrubber_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int ACC_CYC   = DEF_ACC_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              Xin,
  input  logic              RESETn,
  input  logic              scrub_en,
  input  logic [15:0]       interval,
  input  logic              cpu_req,
  input  logic              cnt_clr,
  output logic              corr_pulse,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic              pass_done,
  output scrub_state_t      dbg_state,
  edac_scrubber_if.master   ram
);

  localparam logic [ACC_W-1:0]  ACC_LAST  = ACC_W'(ACC_CYC - 1);
  localparam logic [ADDR_W-1:0] ADR_LAST  = '1;
  localparam logic              BANK_LAST = 1'(NUM_BANKS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  scrub_state_t      state;
  logic [ACC_W-1:0]  acc_cnt;
  logic [15:0]       wait_cnt;
  logic [ADDR_W-1:0] adr;
  logic              bank;
  logic [7:0]        d0_q;
  logic [7:0]        d1_q;
  logic [7:0]        d2_q;
  logic [7:0]        wdata_q;
  logic [7:0]        vote;
  logic              mismatch;
  logic              allowed;
  logic              last_word;

  // Majority of the sampled copies; evaluated while in VOTE.
  tmr_vote8 u_vote (
    .d0       (d0_q),
    .d1       (d1_q),
    .d2       (d2_q),
    .vote     (vote),
    .mismatch (mismatch)
  );

  // The port is usable only when enabled and the CPU is not asking for it
  // this very cycle; this gating is what keeps the CPU latency unchanged.
  assign allowed   = scrub_en & ~cpu_req;
  assign last_word = (adr == ADR_LAST) && (bank == BANK_LAST);

  assign ram.grant     = state_owns_port(state) & allowed;
  assign ram.mem_rd    = (state == ST_READ)  & allowed;
  assign ram.mem_wr    = (state == ST_WRITE) & allowed;
  assign ram.mem_adr   = adr;
  assign ram.mem_bank  = bank;
  assign ram.mem_wdata = wdata_q;
  assign dbg_state     = state;

  // Scrub sequencer: word timing, abort/retry, address walk and pulses.
  always_ff @(posedge Xin or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      acc_cnt    <= '0;
      wait_cnt   <= '0;
      adr        <= '0;
      bank       <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      d2_q       <= '0;
      wdata_q    <= '0;
      corr_pulse <= 1'b0;
      pass_done  <= 1'b0;
    end else begin
      corr_pulse <= 1'b0;
      pass_done  <= 1'b0;
      if (!scrub_en) begin
        // Address is kept so a later enable resumes on the same word.
        state   <= ST_IDLE;
        acc_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            wait_cnt <= interval;
            state    <= ST_WAIT;
          end
          ST_WAIT: begin
            if (wait_cnt == 16'd0) state <= ST_REQ;
            else                   wait_cnt <= wait_cnt - 16'd1;
          end
          ST_REQ: begin
            if (!cpu_req) begin
              acc_cnt <= '0;
              state   <= ST_READ;
            end
          end
          ST_READ: begin
            if (cpu_req) begin
              acc_cnt <= '0;
              state   <= ST_REQ;
            end else if (acc_cnt == ACC_LAST) begin
              d0_q    <= ram.mem_rdata0;
              d1_q    <= ram.mem_rdata1;
              d2_q    <= ram.mem_rdata2;
              acc_cnt <= '0;
              state   <= ST_VOTE;
            end else begin
              acc_cnt <= acc_cnt + ACC_W'(1);
            end
          end
          ST_VOTE: begin
            if (cpu_req) begin
              acc_cnt <= '0;
              state   <= ST_REQ;
            end else if (mismatch) begin
              wdata_q <= vote;
              acc_cnt <= '0;
              state   <= ST_WRITE;
            end else begin
              pass_done <= last_word;
              state     <= ST_NEXT;
            end
          end
          ST_WRITE: begin
            if (cpu_req) begin
              // Partial writeback is harmless: the retry re-reads and re-votes.
              acc_cnt <= '0;
              state   <= ST_REQ;
            end else if (acc_cnt == ACC_LAST) begin
              corr_pulse <= 1'b1;
              pass_done  <= last_word;
              acc_cnt    <= '0;
              state      <= ST_NEXT;
            end else begin
              acc_cnt <= acc_cnt + ACC_W'(1);
            end
          end
          ST_NEXT: begin
            if (adr == ADR_LAST) begin
              adr  <= '0;
              bank <= (bank == BANK_LAST) ? 1'b0 : bank + 1'b1;
            end else begin
              adr <= adr + ADDR_W'(1);
            end
            wait_cnt <= interval;
            state    <= ST_WAIT;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Saturating correction counter; a clear coincident with a correction
  // keeps that correction so no event is lost.
  always_ff @(posedge Xin or negedge RESETn) begin
    if (!RESETn) begin
      corr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= corr_pulse ? CNT_W'(1) : '0;
    end else if (corr_pulse && (corr_cnt != CNT_MAX)) begin
      corr_cnt <= corr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/edac_scrubber.md
Name: edac_scrubber

Overview:
- Background scrubber for the triple-redundant EDAC RAM behind ECS0/ECS1.
- Walks every address of both banks and reads all three copies of each byte. Forms a bitwise majority; if any copy disagrees, writes the voted byte back to all three copies.
- Shares the RAM port with the CPU: the CPU always wins, and the scrubber only runs in idle bus time.
- Sits between the CPU bus decode and the RAM mux. Its correction count is exposed as an I/O register alongside the existing read-error counter.

Parameters:
- ADDR_W, 19, byte address width per bank.
- NUM_BANKS, 2, banks scrubbed (0=ECS0, 1=ECS1).
- ACC_CYC, 3, Xin cycles per RAM read or write strobe (range 1..15).
- CNT_W, 8, width of the correction counter.

Ports:
- Xin  in  1  system clock, all state on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- scrub_en  in  1  enable from config register; level-sensitive.
- interval  in  16  idle Xin cycles between successive scrub words; 0 = back-to-back.
- cpu_req  in  1  CPU memory cycle decoded (ECS0|ECS1) this cycle.
- grant  out  1  scrubber drives RAM port (mux select).
- mem_bank  out  1  bank select during scrub.
- mem_adr  out  ADDR_W  scrub address.
- mem_rd  out  1  read strobe to all three copies.
- mem_wr  out  1  write strobe to all three copies.
- mem_rdata0, mem_rdata1, mem_rdata2  in  8 each  the three copies.
- mem_wdata  out  8  voted byte.
- corr_pulse  out  1  one-cycle pulse per corrected word.
- corr_cnt  out  CNT_W  saturating count of corrected words.
- cnt_clr  in  1  synchronous clear of corr_cnt (from read-and-clear decode).
- pass_done  out  1  one-cycle pulse when the full sweep wraps.

Behaviour:
- Reset values:
  - grant, mem_rd, mem_wr, corr_pulse, pass_done = 0.
  - mem_adr, mem_bank, corr_cnt, mem_wdata = 0.
  - State IDLE, interval counter 0.
- FSM states:
  - IDLE: scrub_en=1 goes to WAIT.
  - WAIT: counts interval cycles, then goes to REQ. interval=0 passes through WAIT in 1 cycle.
  - REQ: waits for cpu_req=0, then goes to READ.
  - READ: mem_rd held ACC_CYC cycles; the three copies are sampled on the last cycle; goes to VOTE.
  - VOTE: 1 cycle. V = (d0&d1)|(d1&d2)|(d0&d2). Mismatch if any copy ≠ V. Mismatch goes to WRITE, otherwise NEXT.
  - WRITE: mem_wr held ACC_CYC cycles, mem_wdata=V; goes to NEXT.
  - NEXT: 1 cycle, advances the address, goes to WAIT.
- Grant and arbitration:
  - In READ/VOTE/WRITE, grant = owns & ~cpu_req, combinational. mem_rd and mem_wr are gated the same way.
  - The CPU therefore sees no added latency.
- Abort rules:
  - cpu_req=1 in READ, VOTE or WRITE aborts the word: next state is REQ, same address, access counter reset.
  - The word is always re-read after an abort, so a CPU write landing between read and writeback is never overwritten with stale data.
  - A partial writeback is harmless because the re-read re-votes the word.
- Address advance:
  - mem_adr increments in NEXT.
  - At 2^ADDR_W-1, mem_adr wraps to 0 and mem_bank increments.
  - At the last bank, mem_bank wraps to 0 and pass_done pulses in the NEXT cycle.
- Corrections:
  - corr_pulse is asserted in the cycle WRITE completes; an aborted write produces no pulse.
  - corr_cnt increments on corr_pulse and saturates at 2^CNT_W-1.
  - cnt_clr and corr_pulse in the same cycle give corr_cnt = 1; no event is lost.
- Disable:
  - scrub_en=0 in any state goes to IDLE next cycle; grant, mem_rd, mem_wr drop immediately (gated).
  - mem_adr and mem_bank are retained, so re-enable resumes at the same word.
- interval is sampled on entry to WAIT; changes mid-count take effect on the next word.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, WAIT, REQ, READ, VOTE, WRITE, NEXT);
  - default ADDR_W and ACC_CYC;
  - I/O register offsets for the scrub enable/interval and correction count (read, read-and-clear).
- One natural sub-module, tmr_vote8: combinational 8-bit majority plus mismatch flag. It is reused by the CPU-read EDAC path.

Test Plan:
- Clean RAM, scrub_en=1, interval=0, ADDR_W reduced to 4 → 32 READs with no mem_wr. pass_done pulses once after word 31; corr_cnt=0.
- Copy1 of bank0 adr 5 XOR 0x10, copies0/2=0xA5 → one WRITE to adr 5 with mem_wdata=0xA5. All copies read back 0xA5; corr_cnt=1.
- Errors spread across copies at adr 6: copy0 bit0, copy2 bit7 flipped, original 0x3C → write 0x3C, corr_pulse once.
- cpu_req pulse during the 2nd READ cycle at adr 3 → grant=0 same cycle, then retry of adr 3. A CPU write of 0x77 to adr 3 before the retry is not overwritten.
- Force 300 corrections → corr_cnt=255. Assert cnt_clr coincident with a corr_pulse → corr_cnt=1.
- scrub_en dropped in WRITE at adr 9 → mem_wr=0 next cycle, IDLE. On re-enable, scrub resumes at adr 9 and completes the correction.
